// File: rtl/jtag_pkg.sv
// Shared types for the JTAG TAP controller: 1149.1 state encodings and helpers.
package jtag_pkg;

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SH_DR    = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SH_IR    = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } tap_state_e;

    localparam int TLR_TMS_ONES = 5;

    // The encoding is chosen so that bit 3 alone steers the TDO mux to the IR path.
    function automatic logic tap_select(input tap_state_e s);
        return s[3];
    endfunction

endpackage

// File: rtl/jtag_tap_controller_if.sv
// TAP-side bundle: TMS from the pins, sequencing controls out to the IR/DR chains.
interface jtag_tap_controller_if;

    logic       TMS;
    logic       ShiftIR;
    logic       ClockIR;
    logic       UpdateIR;
    logic       ShiftDR;
    logic       ClockDR;
    logic       UpdateDR;
    logic       Select;
    logic       Enable;
    logic       TLResetn;
    logic [3:0] TAPState;

    modport master (
        input  TMS,
        output ShiftIR, ClockIR, UpdateIR,
        output ShiftDR, ClockDR, UpdateDR,
        output Select, Enable, TLResetn, TAPState
    );

    modport slave (
        output TMS,
        input  ShiftIR, ClockIR, UpdateIR,
        input  ShiftDR, ClockDR, UpdateDR,
        input  Select, Enable, TLResetn, TAPState
    );

endinterface

// File: rtl/jtag_clock_gate.sv
// Latch-based gate: enable is captured while clk is low, so the gated output cannot
// change during the high phase. IDLE_HIGH selects the idle-high clock or idle-low strobe form.
module jtag_clock_gate #(
    parameter bit IDLE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic gclk
);

    logic en_lat;

    // Reset clears the latch directly so an abort never leaves a partial pulse behind.
    always_latch begin
        if (!rst_n) begin
            en_lat <= 1'b0;
        end else if (!clk) begin
            en_lat <= en;
        end
    end

    assign gclk = IDLE_HIGH ? (clk | ~en_lat) : (~clk & en_lat);

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: TMS-steered 16-state FSM plus negedge-registered chain controls.
// States: TLR reset | RTI idle | SEL_xR select | CAP_xR capture | SH_xR shift
//         EX1_xR/EX2_xR exit | PAUSE_xR pause | UPD_xR update (x = D or I)
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter bit GATE_CLOCKS = 1'b1
) (
    input logic                   TCK,
    input logic                   TRSTn,
    jtag_tap_controller_if.master tap
);

    tap_state_e state_q, state_d, state_nxt;
    logic       rst_ok_q, rst_ok_d;

    logic shift_ir_q, shift_ir_d;
    logic shift_dr_q, shift_dr_d;
    logic enable_q, enable_d;
    logic tlreset_n_q, tlreset_n_d;
    logic select_q, select_d;
    logic irclk_en_q, irclk_en_d;
    logic drclk_en_q, drclk_en_d;
    logic updir_en_q, updir_en_d;
    logic upddr_en_q, upddr_en_d;

    logic clock_ir_g, clock_dr_g, update_ir_g, update_dr_g;

    // Release of TRSTn is taken on a falling edge so the FSM never sees it near posedge.
    assign rst_ok_d = 1'b1;

    always_ff @(negedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            rst_ok_q <= 1'b0;
        end else begin
            rst_ok_q <= rst_ok_d;
        end
    end

    always_ff @(posedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            TLR:      state_nxt = tap.TMS ? TLR    : RTI;
            RTI:      state_nxt = tap.TMS ? SEL_DR : RTI;
            SEL_DR:   state_nxt = tap.TMS ? SEL_IR : CAP_DR;
            CAP_DR:   state_nxt = tap.TMS ? EX1_DR : SH_DR;
            SH_DR:    state_nxt = tap.TMS ? EX1_DR : SH_DR;
            EX1_DR:   state_nxt = tap.TMS ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_nxt = tap.TMS ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_nxt = tap.TMS ? UPD_DR : SH_DR;
            UPD_DR:   state_nxt = tap.TMS ? SEL_DR : RTI;
            SEL_IR:   state_nxt = tap.TMS ? TLR    : CAP_IR;
            CAP_IR:   state_nxt = tap.TMS ? EX1_IR : SH_IR;
            SH_IR:    state_nxt = tap.TMS ? EX1_IR : SH_IR;
            EX1_IR:   state_nxt = tap.TMS ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_nxt = tap.TMS ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_nxt = tap.TMS ? UPD_IR : SH_IR;
            UPD_IR:   state_nxt = tap.TMS ? SEL_DR : RTI;
            default:  state_nxt = TLR;
        endcase
        state_d = rst_ok_q ? state_nxt : TLR;
    end

    always_comb begin
        shift_ir_d  = (state_q == SH_IR);
        shift_dr_d  = (state_q == SH_DR);
        enable_d    = shift_ir_d | shift_dr_d;
        tlreset_n_d = (state_q != TLR);
        select_d    = tap_select(state_q);
        irclk_en_d  = (state_q == CAP_IR) || (state_q == SH_IR);
        drclk_en_d  = (state_q == CAP_DR) || (state_q == SH_DR);
        updir_en_d  = (state_q == UPD_IR);
        upddr_en_d  = (state_q == UPD_DR);
    end

    // Falling-edge update gives the chain a half period of setup before the next TCK rise.
    always_ff @(negedge TCK or negedge TRSTn) begin
        if (!TRSTn) begin
            shift_ir_q  <= 1'b0;
            shift_dr_q  <= 1'b0;
            enable_q    <= 1'b0;
            tlreset_n_q <= 1'b0;
            select_q    <= 1'b1;
            irclk_en_q  <= 1'b0;
            drclk_en_q  <= 1'b0;
            updir_en_q  <= 1'b0;
            upddr_en_q  <= 1'b0;
        end else begin
            shift_ir_q  <= shift_ir_d;
            shift_dr_q  <= shift_dr_d;
            enable_q    <= enable_d;
            tlreset_n_q <= tlreset_n_d;
            select_q    <= select_d;
            irclk_en_q  <= irclk_en_d;
            drclk_en_q  <= drclk_en_d;
            updir_en_q  <= updir_en_d;
            upddr_en_q  <= upddr_en_d;
        end
    end

    jtag_clock_gate #(.IDLE_HIGH(1'b1)) u_gate_clock_ir (
        .clk   (TCK),
        .rst_n (TRSTn),
        .en    (irclk_en_q),
        .gclk  (clock_ir_g)
    );

    jtag_clock_gate #(.IDLE_HIGH(1'b1)) u_gate_clock_dr (
        .clk   (TCK),
        .rst_n (TRSTn),
        .en    (drclk_en_q),
        .gclk  (clock_dr_g)
    );

    jtag_clock_gate #(.IDLE_HIGH(1'b0)) u_gate_update_ir (
        .clk   (TCK),
        .rst_n (TRSTn),
        .en    (updir_en_q),
        .gclk  (update_ir_g)
    );

    jtag_clock_gate #(.IDLE_HIGH(1'b0)) u_gate_update_dr (
        .clk   (TCK),
        .rst_n (TRSTn),
        .en    (upddr_en_q),
        .gclk  (update_dr_g)
    );

    assign tap.ClockIR  = GATE_CLOCKS ? clock_ir_g  : irclk_en_q;
    assign tap.ClockDR  = GATE_CLOCKS ? clock_dr_g  : drclk_en_q;
    assign tap.UpdateIR = GATE_CLOCKS ? update_ir_g : updir_en_q;
    assign tap.UpdateDR = GATE_CLOCKS ? update_dr_g : upddr_en_q;

    assign tap.ShiftIR  = shift_ir_q;
    assign tap.ShiftDR  = shift_dr_q;
    assign tap.Enable   = enable_q;
    assign tap.TLResetn = tlreset_n_q;
    assign tap.Select   = select_q;
    assign tap.TAPState = state_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed plus random-TMS bench for jtag_tap_controller against a table-driven TAP model.
module tb_jtag_tap_controller;

    localparam logic [3:0] S_TLR  = 4'hF, S_RTI  = 4'hC, S_SDR  = 4'h7, S_CDR = 4'h6;
    localparam logic [3:0] S_SHDR = 4'h2, S_E1DR = 4'h1, S_PDR  = 4'h3, S_E2DR = 4'h0;
    localparam logic [3:0] S_UDR  = 4'h5, S_SIR  = 4'h4, S_CIR  = 4'hE, S_SHIR = 4'hA;
    localparam logic [3:0] S_E1IR = 4'h9, S_PIR  = 4'hB, S_E2IR = 4'h8, S_UIR  = 4'hD;

    logic tck    = 1'b0;
    logic trst_n = 1'b0;

    jtag_tap_controller_if tap_if();

    jtag_tap_controller #(.GATE_CLOCKS(1'b1)) dut (
        .TCK   (tck),
        .TRSTn (trst_n),
        .tap   (tap_if)
    );

    always #10 tck = ~tck;

    int errors = 0;
    int checks = 0;
    int ir_edges = 0, dr_edges = 0;
    int exp_ir = 0, exp_dr = 0;
    int upd_ir_seen = 0, upd_dr_seen = 0;

    logic [3:0] ms = S_TLR;
    bit         m_hold = 1'b1;
    logic [3:0] nxt0 [16];
    logic [3:0] nxt1 [16];

    logic [3:0] dr_exp [10] = '{S_SDR, S_CDR, S_SHDR, S_SHDR, S_E1DR,
                                S_PDR, S_E2DR, S_SHDR, S_E1DR, S_UDR};
    bit         dr_tms [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Only rising edges coincident with TCK high count as chain clock edges.
    always @(posedge tap_if.ClockIR) if (tck === 1'b1) ir_edges++;
    always @(posedge tap_if.ClockDR) if (tck === 1'b1) dr_edges++;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_low_phase();
        logic ir_clk_state, dr_clk_state;
        ir_clk_state = (ms == S_CIR) || (ms == S_SHIR);
        dr_clk_state = (ms == S_CDR) || (ms == S_SHDR);
        chk("ShiftIR",  tap_if.ShiftIR,  4'(ms == S_SHIR));
        chk("ShiftDR",  tap_if.ShiftDR,  4'(ms == S_SHDR));
        chk("Enable",   tap_if.Enable,   4'((ms == S_SHIR) || (ms == S_SHDR)));
        chk("TLResetn", tap_if.TLResetn, 4'(ms != S_TLR));
        chk("Select",   tap_if.Select,   4'(ms[3]));
        chk("ClockIR_lo",  tap_if.ClockIR,  4'(!ir_clk_state));
        chk("ClockDR_lo",  tap_if.ClockDR,  4'(!dr_clk_state));
        chk("UpdateIR_lo", tap_if.UpdateIR, 4'(ms == S_UIR));
        chk("UpdateDR_lo", tap_if.UpdateDR, 4'(ms == S_UDR));
        if (tap_if.UpdateIR === 1'b1) upd_ir_seen++;
        if (tap_if.UpdateDR === 1'b1) upd_dr_seen++;
    endtask

    // One TCK period: drive TMS in the low phase, check state after the rise, outputs after the fall.
    task automatic tick(input logic t);
        tap_if.TMS = t;
        @(posedge tck);
        if ((ms == S_CIR) || (ms == S_SHIR)) exp_ir++;
        if ((ms == S_CDR) || (ms == S_SHDR)) exp_dr++;
        if (!m_hold) ms = t ? nxt1[ms] : nxt0[ms];
        #2;
        chk("TAPState", tap_if.TAPState, ms);
        chk("ClockIR_hi",  tap_if.ClockIR,  4'h1);
        chk("ClockDR_hi",  tap_if.ClockDR,  4'h1);
        chk("UpdateIR_hi", tap_if.UpdateIR, 4'h0);
        chk("UpdateDR_hi", tap_if.UpdateDR, 4'h0);
        chk_int("ir_edges", ir_edges, exp_ir);
        chk_int("dr_edges", dr_edges, exp_dr);
        @(negedge tck);
        m_hold = 1'b0;
        #2;
        chk_low_phase();
    endtask

    initial begin
        int base;
        int n;

        nxt0[S_TLR]  = S_RTI;  nxt1[S_TLR]  = S_TLR;
        nxt0[S_RTI]  = S_RTI;  nxt1[S_RTI]  = S_SDR;
        nxt0[S_SDR]  = S_CDR;  nxt1[S_SDR]  = S_SIR;
        nxt0[S_SIR]  = S_CIR;  nxt1[S_SIR]  = S_TLR;
        nxt0[S_CDR]  = S_SHDR; nxt1[S_CDR]  = S_E1DR;
        nxt0[S_SHDR] = S_SHDR; nxt1[S_SHDR] = S_E1DR;
        nxt0[S_E1DR] = S_PDR;  nxt1[S_E1DR] = S_UDR;
        nxt0[S_PDR]  = S_PDR;  nxt1[S_PDR]  = S_E2DR;
        nxt0[S_E2DR] = S_SHDR; nxt1[S_E2DR] = S_UDR;
        nxt0[S_UDR]  = S_RTI;  nxt1[S_UDR]  = S_SDR;
        nxt0[S_CIR]  = S_SHIR; nxt1[S_CIR]  = S_E1IR;
        nxt0[S_SHIR] = S_SHIR; nxt1[S_SHIR] = S_E1IR;
        nxt0[S_E1IR] = S_PIR;  nxt1[S_E1IR] = S_UIR;
        nxt0[S_PIR]  = S_PIR;  nxt1[S_PIR]  = S_E2IR;
        nxt0[S_E2IR] = S_SHIR; nxt1[S_E2IR] = S_UIR;
        nxt0[S_UIR]  = S_RTI;  nxt1[S_UIR]  = S_SDR;

        // Reset values while TRSTn is held low.
        tap_if.TMS = 1'b1;
        repeat (2) @(negedge tck);
        #2;
        chk("rst_TAPState", tap_if.TAPState, S_TLR);
        chk("rst_TLResetn", tap_if.TLResetn, 4'h0);
        chk("rst_ShiftIR",  tap_if.ShiftIR,  4'h0);
        chk("rst_ShiftDR",  tap_if.ShiftDR,  4'h0);
        chk("rst_Enable",   tap_if.Enable,   4'h0);
        chk("rst_Select",   tap_if.Select,   4'h1);
        chk("rst_ClockIR",  tap_if.ClockIR,  4'h1);
        chk("rst_ClockDR",  tap_if.ClockDR,  4'h1);
        chk("rst_UpdateIR", tap_if.UpdateIR, 4'h0);
        chk("rst_UpdateDR", tap_if.UpdateDR, 4'h0);

        // Release in the low phase: first posedge holds TLR, second moves to RTI.
        trst_n = 1'b1;
        ms = S_TLR;
        m_hold = 1'b1;
        tick(1'b0);
        chk("release_hold", tap_if.TAPState, S_TLR);
        tick(1'b0);
        chk("release_rti", tap_if.TAPState, S_RTI);

        // IR capture and shift clocking.
        base = ir_edges;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        chk("cap_ir", tap_if.TAPState, S_CIR);
        tick(1'b0);
        chk("sh_ir", tap_if.TAPState, S_SHIR);
        chk("sh_ir_shift", tap_if.ShiftIR, 4'h1);
        chk("sh_ir_enable", tap_if.Enable, 4'h1);
        repeat (3) tick(1'b0);
        tick(1'b1);
        chk("ex1_ir", tap_if.TAPState, S_E1IR);
        chk_int("ir_clock_count", ir_edges - base, 5);

        // IR update strobe.
        upd_ir_seen = 0;
        tick(1'b1);
        chk("upd_ir", tap_if.TAPState, S_UIR);
        chk("upd_ir_pulse", tap_if.UpdateIR, 4'h1);
        tick(1'b0);
        chk_int("upd_ir_once", upd_ir_seen, 1);
        chk_int("ir_no_extra_clock", ir_edges - base, 5);

        // DR walk including pause and re-entry to shift.
        base = dr_edges;
        upd_dr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(dr_tms[i]);
            chk("dr_walk", tap_if.TAPState, dr_exp[i]);
            chk("dr_select", tap_if.Select, 4'h0);
        end
        tick(1'b0);
        chk_int("dr_clock_count", dr_edges - base, 4);
        chk_int("upd_dr_once", upd_dr_seen, 1);

        // Abort with TRSTn in the low phase of Shift-IR.
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        chk("abort_in_shir", tap_if.ClockIR, 4'h0);
        #1;
        trst_n = 1'b0;
        #1;
        chk("abort_TAPState", tap_if.TAPState, S_TLR);
        chk("abort_ClockIR",  tap_if.ClockIR,  4'h1);
        chk("abort_ShiftIR",  tap_if.ShiftIR,  4'h0);
        chk("abort_Enable",   tap_if.Enable,   4'h0);
        chk("abort_TLResetn", tap_if.TLResetn, 4'h0);
        base = ir_edges;
        repeat (2) @(posedge tck);
        @(negedge tck);
        #2;
        chk_int("abort_no_edge", ir_edges - base, 0);
        chk("abort_ClockIR_held", tap_if.ClockIR, 4'h1);
        trst_n = 1'b1;
        ms = S_TLR;
        m_hold = 1'b1;
        tick(1'b0);
        tick(1'b0);

        // Five ones from every state lands in Test-Logic-Reset.
        for (int s = 0; s < 16; s++) begin
            n = 0;
            while (ms != 4'(s) && n < 200) begin
                tick(1'($urandom_range(0, 1)));
                n++;
            end
            chk("reach_state", tap_if.TAPState, 4'(s));
            repeat (5) tick(1'b1);
            chk("five_ones_tlr", tap_if.TAPState, S_TLR);
            chk("five_ones_rstn", tap_if.TLResetn, 4'h0);
        end

        // Random TMS soak against the model.
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
- IEEE 1149.1 TAP controller for the JTAG chain.
- 16-state FSM clocked by TCK and steered by TMS.
- Generates the sequencing controls for the instruction-register cells: ShiftIR, ClockIR and UpdateIR.
- Generates the equivalent DR controls plus TDO mux select, TDO enable and test-logic reset.
- Sits between the chip JTAG pins and the IR/DR chains.

Parameters:
- GATE_CLOCKS, 1, 1 = ClockIR/ClockDR/UpdateIR/UpdateDR are gated TCK pulses; 0 = the same signals are emitted as level enables (registered on TCK falling edge) for a fully synchronous chain.

Ports:
- TCK  input  1  test clock; the only clock.
- TRSTn  input  1  asynchronous active-low reset; forces Test-Logic-Reset.
- TMS  input  1  mode select; sampled on TCK rising edge.
- ShiftIR  output  1  IR cells shift (1) or capture (0).
- ClockIR  output  1  IR cell clock; rising edge ends Capture-IR/Shift-IR.
- UpdateIR  output  1  IR cell update strobe; rising edge in Update-IR.
- ShiftDR  output  1  DR shift select.
- ClockDR  output  1  DR clock; rising edge ends Capture-DR/Shift-DR.
- UpdateDR  output  1  DR update strobe.
- Select  output  1  TDO mux: 1 = IR path, 0 = DR path.
- Enable  output  1  TDO output enable.
- TLResetn  output  1  active-low test-logic reset to the instruction decoder.
- TAPState  output  4  current state, for debug/verification.

Behaviour:
- State register: updated on posedge TCK; async clear by TRSTn=0 to TLR.
- Standard 1149.1 transitions. Each line gives the next state for TMS=0 / TMS=1:
  - TLR → RTI / TLR
  - RTI → RTI / SelDR
  - SelDR → CapDR / SelIR
  - SelIR → CapIR / TLR
  - CapXR → ShXR / Ex1XR
  - ShXR → ShXR / Ex1XR
  - Ex1XR → PauseXR / UpdXR
  - PauseXR → PauseXR / Ex2XR
  - Ex2XR → ShXR / UpdXR
  - UpdXR → RTI / SelDR
- Five consecutive TCK rising edges with TMS=1 reach TLR from any state.
- Negedge-registered outputs (update on negedge TCK; async reset by TRSTn):
  - ShiftIR = (state==ShIR); reset 0.
  - ShiftDR = (state==ShDR); reset 0.
  - Enable = (state in {ShIR, ShDR}); reset 0.
  - TLResetn = !(state==TLR); reset 0.
  - Select = state[3] under the package encoding; reset 1.
- Clock enables:
  - irclk_en = state in {CapIR, ShIR}, registered on negedge.
  - drclk_en = state in {CapDR, ShDR}, registered on negedge.
  - GATE_CLOCKS=1: ClockIR = TCK | ~irclk_en, so it goes low for the TCK-low half and rises with TCK. ClockIR idles high; same form for ClockDR.
  - GATE_CLOCKS=0: ClockIR/ClockDR = the enables themselves.
- Update strobes:
  - updir_en = (state==UpdIR), registered on negedge.
  - GATE_CLOCKS=1: UpdateIR = ~TCK & updir_en, a high pulse over the TCK-low half of Update-IR whose rising edge is the TCK falling edge. Idle 0; UpdateDR identical.
  - GATE_CLOCKS=0: UpdateIR/UpdateDR = the enables themselves.
- Gating implemented via a single glitch-free clock-gate submodule instance per gated output.
- TRSTn assertion mid-shift:
  - State → TLR immediately.
  - All shift/enable/update outputs drop at once; ClockIR/ClockDR return high and emit no partial pulse.
- TRSTn deassertion:
  - Synchronised to TCK falling edge inside the block.
  - First state change occurs only on the second posedge TCK after release.
- Output latency: outputs reflect the state entered at posedge TCK from the following negedge TCK.

Decomposition:
- Package jtag_pkg holds:
  - 4-bit state typedef and the 16 encodings: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
  - Constant TLR_TMS_ONES=5.
- One submodule, jtag_clock_gate: latch/AND gate, instanced four times; a bypass mux selects it when GATE_CLOCKS=1.

Test Plan:
1. TRSTn=0 → TAPState=F, TLResetn=0, ShiftIR=0, Enable=0, Select=1, ClockIR=1, UpdateIR=0. Release and apply TMS=0 → RTI (C) on the second posedge.
2. From RTI, TMS 1,1,0,0 → CapIR (E) then ShIR (A); ShiftIR=1, Enable=1. Stay 4 cycles with TMS=0 → exactly 5 ClockIR rising edges (1 capture + 4 shift), each coincident with TCK rising.
3. From ShIR, TMS 1,1 → Ex1IR then UpdIR (D). Exactly one UpdateIR pulse, rising at TCK falling edge, width 0.5 TCK. No ClockIR edges during Ex1IR/UpdIR.
4. DR path: RTI, TMS 1,0,0,0,1,0,1,0,1,1 → walks SelDR, CapDR, ShDR, ShDR, Ex1DR, PauseDR, Ex2DR, ShDR, Ex1DR, UpdDR. ClockDR edges occur only in CapDR/ShDR, UpdateDR pulses once, Select=0 throughout DR states.
5. From every one of the 16 states, TMS=1 for 5 TCK → TLR (F), TLResetn=0.
6. Assert TRSTn mid-ShIR while TCK is low → ClockIR goes high immediately with no further edge, ShiftIR=0, TAPState=F asynchronously.
